// File: rtl/vec_pe_sched.sv
// Job scheduler for the dual vectoring/rotation PE pair: job FIFO, registered issue stage,
// per-PE completion tracker and drain handshake. Optional same-cycle co-issue: VEC_PE_SCHED_COISSUE_EN.
module vec_pe_sched #(
    parameter int CORDIC_NUM = 14,
    parameter int TAG_W      = 4,
    parameter int DEPTH      = 4,
    parameter int LAT        = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_scheme_i,
    input  logic [1:0]            req_mask_i,
    input  logic [CORDIC_NUM-1:0] req_angle0_i,
    input  logic [CORDIC_NUM-1:0] req_angle1_i,
    input  logic [TAG_W-1:0]      req_tag_i,
    input  logic                  drain_i,
    output logic [1:0]            pe0_valid_o,
    output logic [1:0]            pe1_valid_o,
    output logic [1:0]            pe0_scheme_o,
    output logic [1:0]            pe1_scheme_o,
    output logic [CORDIC_NUM-1:0] angle0_o,
    output logic [CORDIC_NUM-1:0] angle1_o,
    output logic [TAG_W-1:0]      iss0_tag_o,
    output logic [TAG_W-1:0]      iss1_tag_o,
    output logic                  done0_valid_o,
    output logic [TAG_W-1:0]      done0_tag_o,
    output logic                  done1_valid_o,
    output logic [TAG_W-1:0]      done1_tag_o,
    output logic                  busy_o,
    output logic                  drain_done_o
);

    // state   | meaning
    // S_IDLE  | nothing accepted since reset or last drain
    // S_RUN   | accepting and issuing jobs
    // S_DRAIN | no new jobs; waiting for FIFO, issue regs and tracker to empty
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = PW + 1;

    state_t state, state_nxt;
    logic   drain_done_nxt;
    logic   live_q;

    logic [1:0]            fifo_scheme [DEPTH];
    logic [1:0]            fifo_mask   [DEPTH];
    logic [CORDIC_NUM-1:0] fifo_a0     [DEPTH];
    logic [CORDIC_NUM-1:0] fifo_a1     [DEPTH];
    logic [TAG_W-1:0]      fifo_tag    [DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr, src1;
    logic [CNT_W-1:0]      count, pop_cnt;

    logic push, have_one, coissue, sel0, sel1, rr;
    logic act0_q, act1_q;

    logic [LAT-1:0]   trk0_v, trk1_v;
    logic [TAG_W-1:0] trk0_tag [LAT];
    logic [TAG_W-1:0] trk1_tag [LAT];

    assign req_ready_o = live_q && (count < CNT_W'(DEPTH)) && (state != S_DRAIN);
    assign push        = req_valid_i && req_ready_o;

    always_comb begin
        have_one = (count != '0);
        coissue  = 1'b0;
        src1     = rd_ptr;
`ifdef VEC_PE_SCHED_COISSUE_EN
        if (count >= CNT_W'(2)
            && fifo_a0[rd_ptr] == fifo_a0[rd_ptr + PW'(1)]
            && fifo_a1[rd_ptr] == fifo_a1[rd_ptr + PW'(1)]) begin
            coissue = 1'b1;
            src1    = rd_ptr + PW'(1);
        end
`endif
        sel0    = coissue || (have_one && !rr);
        sel1    = coissue || (have_one && rr);
        pop_cnt = coissue ? CNT_W'(2) : (have_one ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_scheme[wr_ptr] <= req_scheme_i;
            fifo_mask[wr_ptr]   <= req_mask_i;
            fifo_a0[wr_ptr]     <= req_angle0_i;
            fifo_a1[wr_ptr]     <= req_angle1_i;
            fifo_tag[wr_ptr]    <= req_tag_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            rr     <= 1'b0;
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + pop_cnt[PW-1:0];
            count  <= count + CNT_W'(push) - pop_cnt;
            if (have_one && !coissue)
                rr <= ~rr;
        end
    end

    // Issue registers: non-selected PEs are zeroed so downstream sees clean idle slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe0_valid_o  <= '0;
            pe1_valid_o  <= '0;
            pe0_scheme_o <= '0;
            pe1_scheme_o <= '0;
            angle0_o     <= '0;
            angle1_o     <= '0;
            iss0_tag_o   <= '0;
            iss1_tag_o   <= '0;
            act0_q       <= 1'b0;
            act1_q       <= 1'b0;
        end else begin
            act0_q       <= sel0;
            act1_q       <= sel1;
            pe0_valid_o  <= sel0 ? fifo_mask[rd_ptr]   : 2'b00;
            pe0_scheme_o <= sel0 ? fifo_scheme[rd_ptr] : 2'b00;
            iss0_tag_o   <= sel0 ? fifo_tag[rd_ptr]    : '0;
            pe1_valid_o  <= sel1 ? fifo_mask[src1]     : 2'b00;
            pe1_scheme_o <= sel1 ? fifo_scheme[src1]   : 2'b00;
            iss1_tag_o   <= sel1 ? fifo_tag[src1]      : '0;
            angle0_o     <= have_one ? fifo_a0[rd_ptr] : '0;
            angle1_o     <= have_one ? fifo_a1[rd_ptr] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk0_v <= '0;
            trk1_v <= '0;
            for (int i = 0; i < LAT; i++) begin
                trk0_tag[i] <= '0;
                trk1_tag[i] <= '0;
            end
        end else begin
            trk0_v[0]   <= act0_q;
            trk1_v[0]   <= act1_q;
            trk0_tag[0] <= iss0_tag_o;
            trk1_tag[0] <= iss1_tag_o;
            for (int i = 1; i < LAT; i++) begin
                trk0_v[i]   <= trk0_v[i-1];
                trk1_v[i]   <= trk1_v[i-1];
                trk0_tag[i] <= trk0_tag[i-1];
                trk1_tag[i] <= trk1_tag[i-1];
            end
        end
    end

    assign done0_valid_o = trk0_v[LAT-1];
    assign done0_tag_o   = trk0_tag[LAT-1];
    assign done1_valid_o = trk1_v[LAT-1];
    assign done1_tag_o   = trk1_tag[LAT-1];
    assign busy_o        = (count != '0) || act0_q || act1_q || (|trk0_v) || (|trk1_v);

    always_comb begin
        state_nxt      = state;
        drain_done_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (push)
                    state_nxt = drain_i ? S_DRAIN : S_RUN;
                else if (drain_i)
                    drain_done_nxt = 1'b1;
            end
            S_RUN: begin
                if (drain_i)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (!busy_o) begin
                    state_nxt      = S_IDLE;
                    drain_done_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            drain_done_o <= 1'b0;
        end else begin
            state        <= state_nxt;
            drain_done_o <= drain_done_nxt;
        end
    end

endmodule
